// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// iterated LSB-first over WIDTH cycles to produce a parallel result.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sb_q;
  logic [WIDTH-2:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, overflow_q;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sum_bits;
  logic             last_bit;

  // Single full-adder cell reused every RUN cycle.
  assign fa_s     = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_c     = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
  assign sum_bits = {fa_s, acc_q};
  assign last_bit = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q       <= '0;
      sb_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (start) begin
        // Subtraction as A + ~B + 1: the +1 enters through the initial carry.
        sa_q    <= a;
        sb_q    <= sub ? ~b : b;
        carry_q <= sub;
        cnt_q   <= '0;
      end
    end else if (state_q == StRun) begin
      acc_q   <= sum_bits[WIDTH-1:1];
      sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= cnt_q + 1'b1;
      if (last_bit) begin
        result_q   <= sum_bits;
        cout_q     <= fa_c;
        overflow_q <= fa_c ^ carry_q;
      end
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule
